// File: rtl/event_counter_bank.sv
// Bank of independent event counters fed by asynchronous inputs, with sticky
// overflow flags and a handshake-driven snapshot into readable shadow registers.
module event_counter_bank #(
  parameter int WIDTH       = 10,
  parameter int CHANNELS    = 4,
  parameter int SAT_MODE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       inc,
  input  logic                      en,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       ovf_clr,
  input  logic                      snap_req,
  output logic                      snap_ack,
  input  logic [3:0]                rd_sel,
  output logic [WIDTH-1:0]          rd_data,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       ovf
);

  localparam logic [WIDTH-1:0] MAX = '1;

  typedef enum logic {IDLE, ACK} snap_state_t;

  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [CHANNELS-1:0] r_hist;
  logic [SYNC_STAGES:0] r_fill;
  logic [CHANNELS-1:0] w_pulse;
  logic [WIDTH-1:0]    r_cnt    [CHANNELS];
  logic [WIDTH-1:0]    r_shadow [CHANNELS];
  logic [CHANNELS-1:0] r_ovf;
  snap_state_t         r_state;
  logic                r_snap_ack;

  // NOTE: non-blocking assignments let every stage sample its neighbour's
  // pre-edge value, so the chain shifts by exactly one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_hist <= '0;
      r_fill <= '0;
    end else begin
      r_sync[0] <= inc;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_hist <= r_sync[SYNC_STAGES-1];
      r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are only trusted once the history flop holds a real post-reset
  // sample; a line held high through reset must fall before it can count.
  assign w_pulse = r_sync[SYNC_STAGES-1] & ~r_hist & {CHANNELS{r_fill[SYNC_STAGES]}};

  // NOTE: counters and shadows are plain flops, not RAM, so they take the
  // asynchronous reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) r_cnt[c] <= '0;
      r_ovf <= '0;
    end else if (clr) begin
      for (int c = 0; c < CHANNELS; c++) r_cnt[c] <= '0;
      r_ovf <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_pulse[c] && en && (r_cnt[c] == MAX)) begin
          r_cnt[c] <= (SAT_MODE != 0) ? MAX : '0;
          r_ovf[c] <= 1'b1;
        end else begin
          if (w_pulse[c] && en) r_cnt[c] <= r_cnt[c] + 1'b1;
          if (ovf_clr[c])       r_ovf[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_snap_ack <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) r_shadow[c] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (snap_req) begin
            for (int c = 0; c < CHANNELS; c++) r_shadow[c] <= r_cnt[c];
            r_state    <= ACK;
            r_snap_ack <= 1'b1;
          end
        end
        ACK: begin
          if (!snap_req) begin
            r_state    <= IDLE;
            r_snap_ack <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_snap_ack <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the default assignment first keeps this block from inferring a latch
  // for out-of-range selects.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_sel == 4'(c)) rd_data = r_shadow[c];
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_count
    assign count[c*WIDTH +: WIDTH] = r_cnt[c];
  end

  assign ovf      = r_ovf;
  assign snap_ack = r_snap_ack;

endmodule

// File: tb/tb_event_counter_bank.sv
// Drives a wrap-mode and a saturate-mode bank with identical stimulus and
// checks both against a behavioural model every cycle plus literal checkpoints.
module tb_event_counter_bank;

  localparam int W   = 10;
  localparam int CH  = 4;
  localparam int S   = 2;
  localparam int MAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] inc;
  logic          en;
  logic          clr;
  logic [CH-1:0] ovf_clr;
  logic          snap_req;
  logic [3:0]    rd_sel;

  logic [CH*W-1:0] count_o [2];
  logic [CH-1:0]   ovf_o   [2];
  logic            ack_o   [2];
  logic [W-1:0]    rd_o    [2];

  int total = 0;
  int bad   = 0;
  bit compare_on = 1'b0;

  always #5 clk = ~clk;

  event_counter_bank #(.WIDTH(W), .CHANNELS(CH), .SAT_MODE(0), .SYNC_STAGES(S)) u_wrap (
    .clk(clk), .rst_n(rst_n), .inc(inc), .en(en), .clr(clr), .ovf_clr(ovf_clr),
    .snap_req(snap_req), .snap_ack(ack_o[0]), .rd_sel(rd_sel), .rd_data(rd_o[0]),
    .count(count_o[0]), .ovf(ovf_o[0])
  );

  event_counter_bank #(.WIDTH(W), .CHANNELS(CH), .SAT_MODE(1), .SYNC_STAGES(S)) u_sat (
    .clk(clk), .rst_n(rst_n), .inc(inc), .en(en), .clr(clr), .ovf_clr(ovf_clr),
    .snap_req(snap_req), .snap_ack(ack_o[1]), .rd_sel(rd_sel), .rd_data(rd_o[1]),
    .count(count_o[1]), .ovf(ovf_o[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ch(input int m, input int c);
    return count_o[m][c*W +: W];
  endfunction

  // Behavioural model: samples taken at each edge, an event is a 0->1 step in
  // the sample stream seen S edges late; index 1 is the saturating bank.
  bit samp [CH][S+1];
  int nsamp;
  int mcnt [2][CH];
  bit movf [2][CH];
  int mshd [2][CH];
  bit mack;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nsamp = 0;
      mack  = 1'b0;
      for (int c = 0; c < CH; c++) begin
        for (int d = 0; d <= S; d++) samp[c][d] = 1'b0;
        for (int m = 0; m < 2; m++) begin
          mcnt[m][c] = 0; movf[m][c] = 1'b0; mshd[m][c] = 0;
        end
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        bit ev;
        ev = (nsamp >= S + 1) && samp[c][S-1] && !samp[c][S];
        for (int m = 0; m < 2; m++) begin
          if (!mack && snap_req) mshd[m][c] = mcnt[m][c];
          if (clr) begin
            mcnt[m][c] = 0;
            movf[m][c] = 1'b0;
          end else if (ev && en && mcnt[m][c] == MAX) begin
            mcnt[m][c] = (m == 1) ? MAX : 0;
            movf[m][c] = 1'b1;
          end else begin
            if (ev && en) mcnt[m][c] = mcnt[m][c] + 1;
            if (ovf_clr[c]) movf[m][c] = 1'b0;
          end
        end
        for (int d = S; d > 0; d--) samp[c][d] = samp[c][d-1];
        samp[c][0] = inc[c];
      end
      if (nsamp < S + 1) nsamp++;
      mack = snap_req;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (compare_on) begin
        for (int m = 0; m < 2; m++) begin
          logic [CH*W-1:0] e_cnt;
          logic [CH-1:0]   e_ovf;
          logic [W-1:0]    e_rd;
          for (int c = 0; c < CH; c++) begin
            e_cnt[c*W +: W] = W'(mcnt[m][c]);
            e_ovf[c]        = movf[m][c];
          end
          e_rd = (int'(rd_sel) < CH) ? W'(mshd[m][int'(rd_sel)]) : '0;
          check($sformatf("model_count_%0d", m), 64'(count_o[m]), 64'(e_cnt));
          check($sformatf("model_ovf_%0d", m), 64'(ovf_o[m]), 64'(e_ovf));
          check($sformatf("model_ack_%0d", m), 64'(ack_o[m]), 64'(mack));
          check($sformatf("model_rd_%0d", m), 64'(rd_o[m]), 64'(e_rd));
        end
      end
    end
  end

  task automatic pulse(input logic [CH-1:0] mask, input int n);
    repeat (n) begin
      @(negedge clk) inc = inc | mask;
      @(negedge clk);
      @(negedge clk) inc = inc & ~mask;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_all();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; inc = '0; en = 1'b1; clr = 1'b0; ovf_clr = '0;
    snap_req = 1'b0; rd_sel = '0;
    #2 rst_n = 1'b0;
    compare_on = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      check("reset_count", 64'(count_o[m]), 64'd0);
      check("reset_ovf", 64'(ovf_o[m]), 64'd0);
      check("reset_ack", 64'(ack_o[m]), 64'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    idle(5);

    // Latency: sampled at edge k, visible after edge k+2.
    @(negedge clk) inc[2] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check("latency_k1", 64'(ch(0, 2)), 64'd0);
    @(posedge clk); #1;
    check("latency_k2", 64'(ch(0, 2)), 64'd1);
    @(negedge clk) inc[2] = 1'b0;
    @(negedge clk);
    pulse(4'b0100, 4);
    idle(4);
    for (int m = 0; m < 2; m++) begin
      check("five_pulses_ch2", 64'(ch(m, 2)), 64'd5);
      check("five_pulses_ch0", 64'(ch(m, 0)), 64'd0);
    end

    pulse(4'b1111, 1);
    idle(4);
    check("all_channels", 64'(count_o[0]), 64'({10'd1, 10'd6, 10'd1, 10'd1}));

    clear_all();
    check("clr_all", 64'(count_o[0]), 64'd0);

    pulse(4'b0001, 1024);
    idle(4);
    check("wrap_ch0", 64'(ch(0, 0)), 64'd0);
    check("wrap_ovf0", 64'(ovf_o[0][0]), 64'd1);
    check("sat_ch0", 64'(ch(1, 0)), 64'd1023);
    check("sat_ovf0", 64'(ovf_o[1][0]), 64'd1);
    @(negedge clk) ovf_clr = 4'b0001;
    @(negedge clk) ovf_clr = '0;
    check("ovf_clr_wrap", 64'(ovf_o[0]), 64'd0);
    check("ovf_clr_sat", 64'(ovf_o[1]), 64'd0);

    pulse(4'b0010, 1030);
    idle(4);
    check("sat_ch1", 64'(ch(1, 1)), 64'd1023);
    check("sat_ovf1", 64'(ovf_o[1][1]), 64'd1);
    check("wrap_ch1", 64'(ch(0, 1)), 64'd6);
    check("wrap_ovf1", 64'(ovf_o[0][1]), 64'd1);

    // Snapshot while channel 3 keeps counting.
    clear_all();
    pulse(4'b1000, 7);
    idle(4);
    @(negedge clk) begin snap_req = 1'b1; rd_sel = 4'd3; inc[3] = 1'b1; end
    @(posedge clk); #1;
    check("snap_ack_rise", 64'(ack_o[0]), 64'd1);
    check("snap_rd_ch3", 64'(rd_o[0]), 64'd7);
    @(negedge clk);
    @(negedge clk) inc[3] = 1'b0;
    idle(2);
    pulse(4'b1000, 1);
    idle(4);
    check("snap_live_ch3", 64'(ch(0, 3)), 64'd9);
    check("snap_hold_rd", 64'(rd_o[1]), 64'd7);
    check("snap_ack_hold", 64'(ack_o[1]), 64'd1);
    @(negedge clk) snap_req = 1'b0;
    @(posedge clk); #1;
    check("snap_ack_fall", 64'(ack_o[0]), 64'd0);

    // clr coincident with an event and with a capture edge.
    clear_all();
    pulse(4'b0001, 4);
    idle(4);
    @(negedge clk) inc[0] = 1'b1;
    @(negedge clk);
    @(negedge clk) begin clr = 1'b1; snap_req = 1'b1; rd_sel = 4'd0; end
    @(negedge clk) begin clr = 1'b0; snap_req = 1'b0; inc[0] = 1'b0; end
    check("clr_beats_event", 64'(ch(0, 0)), 64'd0);
    check("snap_pre_clear", 64'(rd_o[0]), 64'd4);
    idle(4);
    check("clr_event_lost", 64'(ch(1, 0)), 64'd0);

    // Enable gating and out-of-range read select.
    pulse(4'b0001, 2);
    pulse(4'b1000, 3);
    @(negedge clk) en = 1'b0;
    pulse(4'b0001, 3);
    idle(4);
    @(negedge clk) en = 1'b1;
    idle(4);
    check("en_off_ch0", 64'(ch(0, 0)), 64'd2);
    @(negedge clk) begin snap_req = 1'b1; rd_sel = 4'd3; end
    @(negedge clk);
    check("rd_sel3", 64'(rd_o[0]), 64'd3);
    rd_sel = 4'd15;
    #1;
    check("rd_sel15", 64'(rd_o[0]), 64'd0);
    @(negedge clk) begin snap_req = 1'b0; rd_sel = 4'd3; end
    idle(2);

    // Reset in ACK with inc[0] held high.
    @(negedge clk) snap_req = 1'b1;
    @(negedge clk) inc[0] = 1'b1;
    idle(4);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rst_mid_count", 64'(count_o[0]), 64'd0);
    check("rst_mid_ack", 64'(ack_o[0]), 64'd0);
    check("rst_mid_ovf", 64'(ovf_o[1]), 64'd0);
    check("rst_mid_rd", 64'(rd_o[0]), 64'd0);
    snap_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    idle(6);
    check("held_high_no_count", 64'(ch(0, 0)), 64'd0);
    @(negedge clk) inc[0] = 1'b0;
    idle(2);
    @(negedge clk) inc[0] = 1'b1;
    idle(2);
    @(negedge clk) inc[0] = 1'b0;
    idle(4);
    check("rerise_counts", 64'(ch(0, 0)), 64'd1);
    check("no_recapture", 64'(ack_o[0]), 64'd0);

    compare_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
